// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT frame arbiter.
//   N        samples per frame fed to the FFT core
//   DW_IN    input sample width
//   DW_OUT   FFT result word width
//   N_OUT    result words per frame (real block then imag block)
//   TIMEOUT  cycles from burst start to the last result before abort
package fft_pkg;
    localparam int N       = 32;
    localparam int DW_IN   = 11;
    localparam int DW_OUT  = 17;
    localparam int N_OUT   = 64;
    localparam int TIMEOUT = 256;
    localparam int ID_W    = 1;
    localparam int WC_W    = $clog2(N);
    localparam int OC_W    = $clog2(N_OUT);
    localparam int WD_W    = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, LOAD, BURST, WAIT} state_t;
endpackage

// File: rtl/fft_frame_arbiter_if.sv
// Source-side and result-side bus of the FFT frame arbiter.
//   s_valid/s_data/s_ready  two sample sources, bit/slice i = source i
//   out_*                   tagged result word stream, no backpressure
// master = sources + result sink, slave = the arbiter.
interface fft_frame_arbiter_if;
    import fft_pkg::*;
    logic [1:0]         s_valid;
    logic [2*DW_IN-1:0] s_data;
    logic [1:0]         s_ready;
    logic               out_valid;
    logic [DW_OUT-1:0]  out_data;
    logic [ID_W-1:0]    out_id;
    logic               out_first;
    logic               out_last;

    modport master (output s_valid, s_data,
                    input  s_ready, out_valid, out_data, out_id, out_first, out_last);
    modport slave  (input  s_valid, s_data,
                    output s_ready, out_valid, out_data, out_id, out_first, out_last);
endinterface

// File: rtl/fft_frame_buf.sv
// One-frame sample buffer: N x DW_IN registers, one write port,
// combinational read port. Contents are never cleared.
//   clk    clock
//   we     write enable, waddr/wdata write address/data
//   raddr  read address, rdata read data (same cycle)
module fft_frame_buf
    import fft_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [WC_W-1:0]  waddr,
    input  logic [DW_IN-1:0] wdata,
    input  logic [WC_W-1:0]  raddr,
    output logic [DW_IN-1:0] rdata
);
    logic [N-1:0][DW_IN-1:0] mem;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/fft_frame_arbiter.sv
// Shares one 32-point FFT core between two sample sources, a frame at a
// time. Round-robin grant, buffers one frame (sources may stall), replays
// it as an unbroken N-cycle burst, then tags the N_OUT result words with
// the source id. A watchdog resets the FFT if results never arrive.
//   clk, rst         clock, synchronous active-high reset
//   bus              source inputs and tagged result outputs
//   fft_valid_o/x_o  sample burst to the FFT
//   fft_rst_n_o      FFT reset, held low 2 cycles after rst or an abort
//   fft_finish_i/answer_i  FFT result stream
//   frame_done       pulse with the last result word
//   err_timeout      pulse when the watchdog aborts a frame
//   busy             high whenever the FSM is not idle
module fft_frame_arbiter
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    fft_frame_arbiter_if.slave bus,
    output logic              fft_valid_o,
    output logic [DW_IN-1:0]  fft_x_o,
    output logic              fft_rst_n_o,
    input  logic              fft_finish_i,
    input  logic [DW_OUT-1:0] fft_answer_i,
    output logic              frame_done,
    output logic              err_timeout,
    output logic              busy
);
    state_t            state;
    logic              g, last_grant, gn;
    logic [WC_W-1:0]   wcnt, rcnt;
    logic [OC_W-1:0]   ocnt;
    logic [WD_W-1:0]   wdog;
    logic [1:0]        rst_hold;
    logic [1:0]        s_ready_q;
    logic              out_valid_q, out_first_q, out_last_q;
    logic [DW_OUT-1:0] out_data_q;
    logic [ID_W-1:0]   out_id_q;
    logic              wr_en, cap, done, expire, active;
    logic [DW_IN-1:0]  wr_data, rd_data;

    assign bus.s_ready   = s_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;
    assign bus.out_first = out_first_q;
    assign bus.out_last  = out_last_q;

    // Both requesting: alternate; otherwise whoever asks.
    assign gn      = (bus.s_valid == 2'b11) ? ~last_grant : bus.s_valid[1];
    assign wr_en   = (state == LOAD) && bus.s_valid[g] && s_ready_q[g];
    assign wr_data = g ? bus.s_data[2*DW_IN-1:DW_IN] : bus.s_data[DW_IN-1:0];
    assign active  = (state == BURST) || (state == WAIT);
    assign cap     = active && fft_finish_i;
    assign done    = cap && (ocnt == OC_W'(N_OUT-1));
    assign expire  = active && (wdog == WD_W'(TIMEOUT-1));

    fft_frame_buf u_buf (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wcnt),
        .wdata (wr_data),
        .raddr (rcnt),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            g           <= 1'b0;
            last_grant  <= 1'b1;
            wcnt        <= '0;
            rcnt        <= '0;
            ocnt        <= '0;
            wdog        <= '0;
            rst_hold    <= 2'd2;
            fft_rst_n_o <= 1'b0;
            s_ready_q   <= '0;
            fft_valid_o <= 1'b0;
            fft_x_o     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;

            // FFT reset countdown; rst_n releases when the count hits zero.
            if (rst_hold != 2'd0) begin
                rst_hold    <= rst_hold - 2'd1;
                fft_rst_n_o <= (rst_hold == 2'd1);
            end

            if (cap) begin
                out_valid_q <= 1'b1;
                out_data_q  <= fft_answer_i;
                out_id_q    <= g;
                out_first_q <= (ocnt == '0);
                out_last_q  <= done;
                ocnt        <= ocnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    // Hold off arbitration until the FFT is out of reset.
                    if (fft_rst_n_o && (bus.s_valid != 2'b00)) begin
                        g          <= gn;
                        last_grant <= gn;
                        s_ready_q  <= gn ? 2'b10 : 2'b01;
                        state      <= LOAD;
                        busy       <= 1'b1;
                    end
                end
                LOAD: begin
                    if (wr_en) begin
                        wcnt <= wcnt + 1'b1;
                        if (wcnt == WC_W'(N-1)) begin
                            // buf[0] is already stable, so the burst starts
                            // on the very next cycle.
                            s_ready_q   <= '0;
                            state       <= BURST;
                            fft_valid_o <= 1'b1;
                            fft_x_o     <= rd_data;
                            rcnt        <= WC_W'(1);
                            wdog        <= '0;
                        end
                    end
                end
                BURST, WAIT: begin
                    if (state == BURST) begin
                        // rcnt wraps to 0 once buf[N-1] has been issued.
                        if (rcnt == '0) begin
                            fft_valid_o <= 1'b0;
                            fft_x_o     <= '0;
                            state       <= WAIT;
                        end else begin
                            fft_x_o <= rd_data;
                            rcnt    <= rcnt + 1'b1;
                        end
                    end
                    wdog <= wdog + 1'b1;
                    // Completion takes priority over a same-cycle expiry.
                    if (done) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        frame_done  <= 1'b1;
                        ocnt        <= '0;
                        rcnt        <= '0;
                        fft_valid_o <= 1'b0;
                        fft_x_o     <= '0;
                    end else if (expire) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        err_timeout <= 1'b1;
                        ocnt        <= '0;
                        rcnt        <= '0;
                        fft_valid_o <= 1'b0;
                        fft_x_o     <= '0;
                        fft_rst_n_o <= 1'b0;
                        rst_hold    <= 2'd2;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_frame_arbiter.sv
module tb_fft_frame_arbiter;
    import fft_pkg::*;

    typedef struct {
        int data;
        bit id;
        bit first;
        bit last;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_frame_arbiter_if bus();
    logic              fft_valid_o;
    logic [DW_IN-1:0]  fft_x_o;
    logic              fft_rst_n_o;
    logic              fft_finish_i;
    logic [DW_OUT-1:0] fft_answer_i;
    logic              frame_done, err_timeout, busy;

    logic              model_fin = 1'b0;
    logic              stray_fin = 1'b0;
    logic [DW_OUT-1:0] model_ans = '0;
    assign fft_finish_i = model_fin | stray_fin;
    assign fft_answer_i = model_fin ? model_ans : DW_OUT'(5);

    fft_frame_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .fft_valid_o  (fft_valid_o),
        .fft_x_o      (fft_x_o),
        .fft_rst_n_o  (fft_rst_n_o),
        .fft_finish_i (fft_finish_i),
        .fft_answer_i (fft_answer_i),
        .frame_done   (frame_done),
        .err_timeout  (err_timeout),
        .busy         (busy)
    );

    res_t res_q[$];
    int   burst_q[$];
    int   srcq0[$];
    int   srcq1[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_b  = 0;
    int   model_b = 0;
    int   mcnt = 0;
    int   run = 0;
    bit   respond = 1'b0, allow_short = 1'b0, stray_en = 1'b0;
    bit   gap0 = 1'b0, gap1 = 1'b0, model_busy = 1'b0;

    // FFT stub: after a full N-sample burst, answer 100+k+1000*frame.
    initial begin
        forever begin
            @(negedge clk);
            if (!fft_rst_n_o) mcnt = 0;
            else if (fft_valid_o) begin
                mcnt++;
                if (mcnt == N) begin
                    mcnt = 0;
                    if (respond) begin
                        model_busy = 1'b1;
                        repeat (3) @(posedge clk);
                        for (int k = 0; k < N_OUT; k++) begin
                            @(posedge clk); #1;
                            model_fin = 1'b1;
                            model_ans = DW_OUT'(100 + k + 1000 * model_b);
                        end
                        @(posedge clk); #1;
                        model_fin  = 1'b0;
                        model_busy = 1'b0;
                    end
                    model_b++;
                end
            end
        end
    end

    // Monitor: pops expected result words and burst samples.
    always @(negedge clk) begin : mon
        res_t e;
        int   x;
        if (bus.out_valid) begin
            checks++;
            if (res_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out data=%0d id=%0d", bus.out_data, bus.out_id);
            end else begin
                e = res_q.pop_front();
                if (bus.out_data !== DW_OUT'(e.data) || bus.out_id !== e.id ||
                    bus.out_first !== e.first || bus.out_last !== e.last ||
                    frame_done !== e.last) begin
                    errors++;
                    $display("FAIL result got data=%0d id=%0d first=%0d last=%0d done=%0d want data=%0d id=%0d first=%0d last=%0d",
                             bus.out_data, bus.out_id, bus.out_first, bus.out_last, frame_done,
                             e.data, e.id, e.first, e.last);
                end
            end
        end
        if (fft_valid_o) begin
            run++;
            checks++;
            if (burst_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_burst x=%0d", fft_x_o);
            end else begin
                x = burst_q.pop_front();
                if (fft_x_o !== DW_IN'(x)) begin
                    errors++;
                    $display("FAIL burst_sample got=%0d want=%0d", fft_x_o, x);
                end
            end
        end else if (run != 0) begin
            if (!allow_short) begin
                checks++;
                if (run != N) begin
                    errors++;
                    $display("FAIL burst_len got=%0d want=%0d", run, N);
                end
            end
            run = 0;
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic push_frame(input int src, input int base, input bit resp, input bit adv);
        res_t e;
        for (int k = 0; k < N; k++) begin
            if (src == 0) srcq0.push_back(base + k);
            else          srcq1.push_back(base + k);
            burst_q.push_back(base + k);
        end
        if (resp) begin
            for (int k = 0; k < N_OUT; k++) begin
                e.data  = 100 + k + 1000 * exp_b;
                e.id    = (src != 0);
                e.first = (k == 0);
                e.last  = (k == N_OUT - 1);
                res_q.push_back(e);
            end
        end
        if (adv) exp_b++;
    endtask

    // Drives both sources from their queues until both are drained.
    task automatic drive(output int rdy0, output int rdy1);
        int cyc;
        bit hs0, hs1, g0, g1;
        rdy0 = 0; rdy1 = 0; cyc = 0; g0 = 0; g1 = 0;
        @(posedge clk); #1;
        while ((srcq0.size() > 0 || srcq1.size() > 0) && cyc < 3000) begin
            bus.s_valid[0] = (srcq0.size() > 0) && !g0;
            bus.s_valid[1] = (srcq1.size() > 0) && !g1;
            bus.s_data[DW_IN-1:0]       = (srcq0.size() > 0) ? DW_IN'(srcq0[0]) : '0;
            bus.s_data[2*DW_IN-1:DW_IN] = (srcq1.size() > 0) ? DW_IN'(srcq1[0]) : '0;
            stray_fin = stray_en && (cyc % 2 == 0);
            @(negedge clk);
            hs0 = bus.s_valid[0] && bus.s_ready[0];
            hs1 = bus.s_valid[1] && bus.s_ready[1];
            if (bus.s_ready[0]) rdy0++;
            if (bus.s_ready[1]) rdy1++;
            if (stray_en) chk("stray_out_valid", int'(bus.out_valid), 0);
            @(posedge clk); #1;
            if (hs0) begin void'(srcq0.pop_front()); g0 = gap0; end else g0 = 0;
            if (hs1) begin void'(srcq1.pop_front()); g1 = gap1; end else g1 = 0;
            cyc++;
        end
        bus.s_valid = '0;
        stray_fin   = 1'b0;
        if (cyc >= 3000) begin
            checks++; errors++;
            $display("FAIL drive_timeout left0=%0d left1=%0d", srcq0.size(), srcq1.size());
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((res_q.size() > 0 || busy || model_busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_results", res_q.size(), 0);
        chk("drain_idle", int'(busy), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.s_valid = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_s_ready", int'(bus.s_ready), 0);
        chk("rst_fft_valid", int'(fft_valid_o), 0);
        chk("rst_fft_x", int'(fft_x_o), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_err", int'(err_timeout), 0);
        chk("rst_done", int'(frame_done), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); chk("rst_n_lo0", int'(fft_rst_n_o), 0);
        @(negedge clk); chk("rst_n_lo1", int'(fft_rst_n_o), 0);
        @(negedge clk); chk("rst_n_hi", int'(fft_rst_n_o), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end

    initial begin
        int r0, r1, n;
        bus.s_valid = '0;
        bus.s_data  = '0;

        // 1: single frame from source 0
        do_reset();
        respond = 1'b1;
        push_frame(0, 0, 1, 1);
        drive(r0, r1);
        chk("t1_ready0_cycles", r0, N);
        wait_done();

        // 2: both sources always valid, 4 frames alternate 0,1,0,1
        do_reset();
        push_frame(0, 200, 1, 1);
        push_frame(1, 400, 1, 1);
        push_frame(0, 300, 1, 1);
        push_frame(1, 500, 1, 1);
        drive(r0, r1);
        wait_done();

        // 3: source 1 with a gap after every handshake
        gap1 = 1'b1;
        push_frame(1, 600, 1, 1);
        drive(r0, r1);
        chk("t3_ready1_cycles", r1, 2 * N - 1);
        gap1 = 1'b0;
        wait_done();

        // 4: FFT never answers -> watchdog abort, then a normal frame
        respond = 1'b0;
        push_frame(0, 700, 0, 1);
        drive(r0, r1);
        @(negedge clk);
        chk("t4_burst_start", int'(fft_valid_o), 1);
        n = 0;
        while (!err_timeout && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("t4_timeout_cycles", n, TIMEOUT);
        chk("t4_busy", int'(busy), 0);
        chk("t4_rst_n_lo0", int'(fft_rst_n_o), 0);
        @(negedge clk);
        chk("t4_err_pulse", int'(err_timeout), 0);
        chk("t4_rst_n_lo1", int'(fft_rst_n_o), 0);
        @(negedge clk);
        chk("t4_rst_n_hi", int'(fft_rst_n_o), 1);
        respond = 1'b1;
        push_frame(0, 800, 1, 1);
        drive(r0, r1);
        wait_done();

        // 5: stray finish pulses in IDLE, then during LOAD
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1; stray_fin = 1'b1;
            @(posedge clk); #1; stray_fin = 1'b0;
            @(negedge clk);
            chk("t5_idle_out_valid", int'(bus.out_valid), 0);
        end
        stray_en = 1'b1;
        push_frame(1, 900, 1, 1);
        drive(r0, r1);
        stray_en = 1'b0;
        wait_done();

        // 6: rst on the 10th burst cycle, then source 0 wins a tie
        allow_short = 1'b1;
        push_frame(0, 1000, 0, 0);
        drive(r0, r1);
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_fft_valid", int'(fft_valid_o), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_s_ready", int'(bus.s_ready), 0);
        chk("t6_rst_n_lo0", int'(fft_rst_n_o), 0);
        @(negedge clk); chk("t6_rst_n_lo1", int'(fft_rst_n_o), 0);
        @(negedge clk); chk("t6_rst_n_hi", int'(fft_rst_n_o), 1);
        chk("t6_burst_left", burst_q.size(), N - 10);
        burst_q.delete();
        allow_short = 1'b0;
        push_frame(0, 1100, 1, 1);
        push_frame(1, 1200, 1, 1);
        drive(r0, r1);
        wait_done();

        chk("end_burst_q", burst_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
